// File: rtl/flex_pattern_pkg.sv
// Shared types and helpers for the runtime-programmable serial pattern detector.
package flex_pattern_pkg;

  typedef enum logic [1:0] {FILL, SEARCH, MATCH} fpd_state_t;

  // A zero length or one longer than the hardware supports selects the full width.
  function automatic int clamp_len(input int len, input int max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

// File: rtl/flex_pattern_detector_if.sv
// Serial stream, configuration and result signals of the pattern detector.
interface flex_pattern_detector_if #(
  parameter int PAT_WIDTH = 4,
  parameter int CNT_WIDTH = 8
);
  import flex_pattern_pkg::*;

  localparam int LEN_W = $clog2(PAT_WIDTH + 1);

  // i is taken only in cycles where i_valid is high; there is no back-pressure,
  // the detector accepts every qualified bit unless load or clear is also high.
  logic                 i;
  logic                 i_valid;
  logic                 load;
  logic [PAT_WIDTH-1:0] pattern;
  logic [LEN_W-1:0]     pat_len;
  logic                 overlap_en;
  logic                 clear;
  logic                 o;
  logic [CNT_WIDTH-1:0] match_count;
  logic                 count_sat;
  fpd_state_t           dbg_state;

  modport master (
    output i, i_valid, load, pattern, pat_len, overlap_en, clear,
    input  o, match_count, count_sat, dbg_state
  );

  modport slave (
    input  i, i_valid, load, pattern, pat_len, overlap_en, clear,
    output o, match_count, count_sat, dbg_state
  );

endinterface

// File: rtl/fpd_match_counter.sv
// Saturating match counter with synchronous clear.
module fpd_match_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i_clear,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_sat
);

  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_sat;

  assign w_sat = &r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !w_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_sat   = w_sat;

endmodule

// File: rtl/flex_pattern_detector.sv
// Programmable-length serial pattern detector with overlap control and a
// saturating match counter; o is a one-cycle Moore pulse per match.
module flex_pattern_detector
  import flex_pattern_pkg::*;
#(
  parameter int                   PAT_WIDTH = 4,
  parameter int                   CNT_WIDTH = 8,
  parameter logic [PAT_WIDTH-1:0] PAT_RESET = PAT_WIDTH'(4'b1101)
) (
  input logic                    clk,
  input logic                    n_rst,
  flex_pattern_detector_if.slave bus
);

  localparam int                LEN_W    = $clog2(PAT_WIDTH + 1);
  localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(PAT_WIDTH);

  fpd_state_t           r_state;
  fpd_state_t           w_state_nxt;
  logic [PAT_WIDTH-1:0] r_pat;
  logic [LEN_W-1:0]     r_len;
  logic                 r_ovl;
  logic [PAT_WIDTH-1:0] r_hist;
  logic [LEN_W-1:0]     r_fill;

  logic                 w_sample;
  logic [PAT_WIDTH-1:0] w_hist_shift;
  logic [PAT_WIDTH-1:0] w_mask;
  logic [LEN_W-1:0]     w_fill_inc;
  logic                 w_hit;
  logic                 w_enter;

  // load and clear both discard the bit presented in the same cycle.
  assign w_sample     = bus.i_valid && !bus.load && !bus.clear;
  assign w_hist_shift = {r_hist[PAT_WIDTH-2:0], bus.i};
  assign w_fill_inc   = (r_fill >= r_len) ? r_len : r_fill + LEN_W'(1);

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < PAT_WIDTH; k++) begin
      w_mask[k] = (k < int'(r_len));
    end
  end

  assign w_hit   = (w_fill_inc >= r_len) && (((w_hist_shift ^ r_pat) & w_mask) == '0);
  // Without overlap, a bit arriving during MATCH only starts the next fill.
  assign w_enter = w_sample && w_hit && ((r_state != MATCH) || r_ovl);

  always_comb begin
    w_state_nxt = r_state;
    if (bus.load || bus.clear) begin
      w_state_nxt = FILL;
    end else begin
      case (r_state)
        FILL: begin
          if (w_sample && (w_fill_inc >= r_len)) begin
            w_state_nxt = w_enter ? MATCH : SEARCH;
          end
        end
        SEARCH: begin
          if (w_enter) begin
            w_state_nxt = MATCH;
          end
        end
        MATCH: begin
          if (r_ovl) begin
            w_state_nxt = w_enter ? MATCH : SEARCH;
          end else begin
            w_state_nxt = FILL;
          end
        end
        default: w_state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pat  <= PAT_RESET;
      r_len  <= FULL_LEN;
      r_ovl  <= 1'b1;
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      if (bus.load) begin
        r_pat <= bus.pattern;
        r_len <= LEN_W'(clamp_len(int'(bus.pat_len), PAT_WIDTH));
        r_ovl <= bus.overlap_en;
      end
      if (bus.load || bus.clear) begin
        r_hist <= '0;
        r_fill <= '0;
      end else if (w_sample) begin
        r_hist <= w_hist_shift;
        r_fill <= (w_enter && !r_ovl) ? '0 : w_fill_inc;
      end
    end
  end

  fpd_match_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_counter (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_clear (bus.clear),
    .i_inc   (w_enter),
    .o_count (bus.match_count),
    .o_sat   (bus.count_sat)
  );

  assign bus.o         = (r_state == MATCH);
  assign bus.dbg_state = r_state;

endmodule

// File: doc/flex_pattern_detector.md
Name: flex_pattern_detector

Overview:
Parametrised, runtime-programmable serial bit-pattern detector. It generalises the fixed 1101 Moore detector to any pattern up to PAT_WIDTH bits, with a selectable length, overlapping or non-overlapping matching, input qualification and a saturating match counter. It sits on a serial input stream and drives a registered Moore match pulse to downstream control.

Parameters:
PAT_WIDTH, 4, maximum pattern length in bits (at least 2).
CNT_WIDTH, 8, width of match_count.
PAT_RESET, 4'b1101, pattern loaded at reset (PAT_WIDTH bits wide).

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
i  input  1  serial data bit.
i_valid  input  1  i is sampled only when high.
load  input  1  capture pattern, pat_len and overlap_en this cycle.
pattern  input  PAT_WIDTH  new pattern; bit [pat_len-1] is the first bit received, bit 0 is the last.
pat_len  input  $clog2(PAT_WIDTH+1)  active length; 0 or any value above PAT_WIDTH is stored as PAT_WIDTH.
overlap_en  input  1  1 = overlapping matches allowed.
clear  input  1  synchronous clear of match_count, count_sat and history.
o  output  1  Moore match flag, registered.
match_count  output  CNT_WIDTH  number of matches, saturating.
count_sat  output  1  high while match_count is at its maximum.

Behaviour:
- Reset (async, n_rst=0) sets the following:
  - o=0, match_count=0, count_sat=0.
  - History = 0, fill = 0, state FILL.
  - Pattern register = PAT_RESET, length register = PAT_WIDTH, overlap register = 1.
- History is a PAT_WIDTH shift register. On each sampled bit (i_valid=1), history <= {history[PAT_WIDTH-2:0], i}.
- fill counts sampled bits and saturates at the length register.
- A hit occurs when the completing bit is sampled, fill is then at or above len, and the low len bits of the new history equal the low len bits of the pattern register.
- FSM states FILL, SEARCH, MATCH. o = (state == MATCH) and nothing else.
  - FILL: a sampled bit that brings fill to len goes to MATCH on a hit, otherwise to SEARCH. Otherwise remain in FILL.
  - SEARCH: a sampled bit goes to MATCH on a hit. Otherwise remain in SEARCH.
  - MATCH: lasts exactly one clock whatever i_valid does.
    - With overlap on, the next state is SEARCH. If i_valid is high this cycle, that bit is evaluated, so back-to-back MATCH is legal.
    - With overlap off, fill was zeroed on the hit and the next state is FILL. A bit sampled during MATCH counts as fill=1.
- Latency: o rises on the clock edge that samples the completing bit and is visible for the following cycle.
- match_count increments by 1 on every entry to MATCH and stops at 2^CNT_WIDTH-1. count_sat = (match_count == all ones).
- load=1:
  - Captures the new configuration, zeroes fill and history, and sets the state to FILL, so o=0 next cycle.
  - Any i sampled in the same cycle is discarded.
  - match_count is kept.
- clear=1: zeroes match_count, count_sat, fill and history, and sets the state to FILL. clear and load together perform both. clear beats a hit in the same cycle, so there is no increment and no MATCH.
- i_valid=0: history, fill and state hold. A MATCH state still exits after one cycle.
- Reset mid-stream returns every output to its reset value immediately. Partial history is lost.

Decomposition:
- Package flex_pattern_pkg holds:
  - typedef enum logic [1:0] {FILL, SEARCH, MATCH} fpd_state_t;
  - a function that clamps pat_len.
- One sub-module, fpd_match_counter: saturating counter with sync clear, an increment enable, and the CNT_WIDTH parameter.

Test Plan:
1. Hold n_rst=0 for two cycles with i toggling -> o=0 and match_count=0 throughout. After release, the default pattern 1101 is active.
2. Default configuration, stream 1,1,0,1 with i_valid=1 -> o=1 only in the cycle after the fourth bit, and match_count=1.
3. Overlap check, stream 1,1,0,1,1,0,1:
   - overlap_en=1 -> two o pulses, bits 4 and 7.
   - reload with overlap_en=0 -> one pulse, and match_count increments by 1.
4. Load pattern=4'b0010 with pat_len=3, then stream 0,1,0,1,0 -> o after bits 3 and 5 with overlap. A load in the same cycle as a valid bit drops that bit.
5. Stream 1,1,0,1 with i_valid low for 3 cycles between each bit -> exactly one o pulse, one cycle wide.
6. CNT_WIDTH=2 instance, 5 matches -> match_count stops at 3 with count_sat=1. Then clear=1 -> 0. Assert n_rst mid-pattern after 1,1,0 -> outputs are 0 immediately, and a following 1 gives no match.
